pila_ret: RTL and testbench
===========================

PILA_RET -- requirements
Module: pila_ret

Interface
REQ-001 Parameter DEPTH, default 16, number of return-address entries (power of two, at least 2).
REQ-002 Parameter AW, default 10, width of a program-counter value in bits.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 push  input  1  from control unit; store return address this cycle (subroutine call).
REQ-006 pop  input  1  from control unit; release top entry this cycle (subroutine return).
REQ-007 d_in  input  AW  return address to store (PC+1 from datapath); sampled only on an accepted push.
REQ-008 d_out  output  AW  current top entry, combinational from state; feeds PC mux selected by s_pila.
REQ-009 count  output  log2(DEPTH)+1  number of valid entries.
REQ-010 empty  output  1  count == 0.
REQ-011 full  output  1  count == DEPTH.
REQ-012 ovf  output  1  sticky overflow: a push was rejected because the stack was full.
REQ-013 unf  output  1  sticky underflow: a pop was rejected because the stack was empty.

Function
REQ-014 State SHALL consist of a storage array (DEPTH x AW), a pointer sp (0..DEPTH) equal to count, and the ovf/unf flags; there is no other FSM state.
REQ-015 d_out SHALL equal entry[sp-1] when not empty, and all-zero when empty, with zero-cycle latency.
REQ-016 push only, not full: at the edge, entry[sp] <= d_in and sp <= sp+1; the new value is visible on d_out in the next cycle.
REQ-017 pop only, not empty: at the edge, sp <= sp-1; the entry contents are left unchanged; in the same cycle d_out already presents the return address.
REQ-018 push and pop together, not empty: entry[sp-1] <= d_in and sp is unchanged (replace top); d_out shows the old top during that cycle.
REQ-019 push and pop together, empty: behave as push only; unf is not set.
REQ-020 push only, full: sp and storage are unchanged, and ovf <= 1.
REQ-021 pop only, empty: sp is unchanged, and unf <= 1.
REQ-022 With neither push nor pop asserted, all state SHALL hold.
REQ-023 ovf and unf SHALL remain set until reset; no other input clears them.
REQ-024 sp SHALL never wrap: it saturates at 0 and at DEPTH through REQ-020 and REQ-021.
REQ-025 Inputs SHALL be considered only at rising clk edges while reset=1; no combinational path from push/pop to any output.

Reset
REQ-026 reset=0 SHALL asynchronously force sp=0, ovf=0, unf=0, giving count=0, empty=1, full=0 and d_out=0.
REQ-027 Storage array contents need not be reset; they are unobservable while empty.
REQ-028 Reset asserted mid-push or mid-pop SHALL abort the operation; the first edge after reset release is treated as a normal cycle.

Structure
REQ-029 A shared CPU package SHALL hold the PC width (AW=10) and the stack depth (16) so that uc, the datapath and pila_ret agree.
REQ-030 The storage array SHALL be a sub-module mem_pila: one synchronous write port (we, waddr, wdata) and one asynchronous read port; pila_ret contains the pointer, flags and control.

Verification
REQ-031 Reset, then push d_in=0x005 -> count=1, d_out=0x005, empty=0.
REQ-032 Push 0x010, 0x020, 0x030, then pop three times -> d_out reads 0x030, 0x020, 0x010 on successive pop cycles, then empty=1, d_out=0, unf=0.
REQ-033 16 pushes of values 0..15, then a 17th push of 0x3FF -> full=1, count=16, d_out=0x00F, ovf=1; next pop -> d_out=0x00E.
REQ-034 From empty, pop -> unf=1, count=0; then push 0x001 -> count=1, unf still 1.
REQ-035 With stack [0x100, 0x200], push and pop together with d_in=0x2AA -> count=2, d_out=0x2AA next cycle, entry below still 0x100.
REQ-036 After three pushes, assert reset asynchronously between edges -> count=0, empty=1, ovf=unf=0 before the next edge.

Source files
------------

// File: rtl/pila_ret_pkg.sv
// rtl/pila_ret_pkg.sv - shared CPU sizing and return-stack operation codes
package pila_ret_pkg;

  localparam int PC_AW      = 10;
  localparam int PILA_DEPTH = 16;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVF,
    OP_UNF
  } op_e;

endpackage

// File: rtl/mem_pila.sv
// rtl/mem_pila.sv - return-address storage, one sync write port and one async read port
module mem_pila #(
  parameter int DEPTH = 16,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] entry [DEPTH];

  always_ff @(posedge clk) begin
    if (we) entry[waddr] <= wdata;
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/pila_ret.sv
// rtl/pila_ret.sv - saturating return-address stack with sticky overflow/underflow flags
module pila_ret
  import pila_ret_pkg::*;
#(
  parameter int DEPTH = PILA_DEPTH,
  parameter int AW    = PC_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            d_in,
  output logic [AW-1:0]            d_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;

  logic [SW-1:0] sp, sp_next;
  logic [PW-1:0] top, waddr;
  logic [AW-1:0] rdata;
  logic          we;
  op_e           op;

  assign empty = (sp == '0);
  assign full  = (sp == SW'(DEPTH));
  assign top   = PW'(sp - SW'(1));
  assign count = sp;
  assign d_out = empty ? '0 : rdata;

  // push+pop on an empty stack degrades to a plain push, so it never counts as underflow
  always_comb begin
    op = OP_IDLE;
    if (push && pop && !empty) op = OP_REPLACE;
    else if (push && full)     op = OP_OVF;
    else if (push)             op = OP_PUSH;
    else if (pop && empty)     op = OP_UNF;
    else if (pop)              op = OP_POP;
  end

  always_comb begin
    sp_next = sp;
    case (op)
      OP_PUSH: sp_next = sp + SW'(1);
      OP_POP:  sp_next = sp - SW'(1);
      default: sp_next = sp;
    endcase
  end

  always_comb begin
    we    = (op == OP_PUSH) || (op == OP_REPLACE);
    waddr = (op == OP_REPLACE) ? top : sp[PW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp <= sp_next;
      if (op == OP_OVF) ovf <= 1'b1;
      if (op == OP_UNF) unf <= 1'b1;
    end
  end

  mem_pila #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (d_in),
    .raddr (top),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_pila_ret.sv
// tb/tb_pila_ret.sv - directed bench for pila_ret with an expected-value queue
module tb_pila_ret;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop;
  logic [9:0] d_in;
  logic [9:0] d_out;
  logic [4:0] count;
  logic       empty, full, ovf, unf;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];
  logic [9:0] pre_out;

  pila_ret dut (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .d_in  (d_in),
    .d_out (d_out),
    .count (count),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle; pre_out captures d_out while the request is still applied
  task automatic cyc(input logic p, input logic q, input logic [9:0] d);
    @(negedge clk);
    push = p; pop = q; d_in = d;
    #1 pre_out = d_out;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; d_in = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_dout",  d_out, 0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_unf",   unf,   0);
    @(negedge clk);
    reset = 1'b1;

    cyc(1, 0, 10'h005);
    chk("push1_count", count, 1);
    chk("push1_dout",  d_out, 10'h005);
    chk("push1_empty", empty, 0);

    do_reset();
    cyc(1, 0, 10'h010); exp_q.push_back(10'h030);
    cyc(1, 0, 10'h020); exp_q.push_back(10'h020);
    cyc(1, 0, 10'h030); exp_q.push_back(10'h010);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 10'h000);
      chk("lifo_pop_dout", pre_out, exp_q.pop_front());
    end
    chk("lifo_empty", empty, 1);
    chk("lifo_dout0", d_out, 0);
    chk("lifo_unf",   unf,   0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 10'(i));
      chk("fill_count", count, i + 1);
    end
    cyc(1, 0, 10'h3FF);
    chk("ovf_full",  full,  1);
    chk("ovf_count", count, 16);
    chk("ovf_dout",  d_out, 10'h00F);
    chk("ovf_flag",  ovf,   1);
    cyc(0, 1, 10'h000);
    chk("ovf_pop_dout", d_out, 10'h00E);
    chk("ovf_pop_full", full,  0);
    chk("ovf_sticky",   ovf,   1);

    do_reset();
    cyc(0, 1, 10'h000);
    chk("unf_flag",  unf,   1);
    chk("unf_count", count, 0);
    cyc(1, 0, 10'h001);
    chk("unf_push_count", count, 1);
    chk("unf_sticky",     unf,   1);
    chk("unf_push_dout",  d_out, 10'h001);

    do_reset();
    cyc(1, 1, 10'h055);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_unf",   unf,   0);
    chk("pp_empty_dout",  d_out, 10'h055);

    do_reset();
    cyc(1, 0, 10'h100);
    cyc(1, 0, 10'h200);
    cyc(1, 1, 10'h2AA);
    chk("repl_pre_dout", pre_out, 10'h200);
    chk("repl_count",    count,   2);
    chk("repl_dout",     d_out,   10'h2AA);
    cyc(0, 0, 10'h3C3);
    chk("idle_count", count, 2);
    chk("idle_dout",  d_out, 10'h2AA);
    cyc(0, 1, 10'h000);
    chk("repl_below", d_out, 10'h100);
    chk("repl_pop_count", count, 1);

    do_reset();
    cyc(0, 1, 10'h000);
    cyc(1, 0, 10'h011);
    cyc(1, 0, 10'h022);
    cyc(1, 0, 10'h033);
    chk("pre_async_count", count, 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_ovf",   ovf,   0);
    chk("async_unf",   unf,   0);
    chk("async_dout",  d_out, 0);
    push = 1'b1; d_in = 10'h044;
    @(posedge clk);
    #1;
    chk("held_rst_count", count, 0);
    push = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 0, 10'h077);
    chk("post_rel_count", count, 1);
    chk("post_rel_dout",  d_out, 10'h077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
